overvoltage_trip_encoder: RTL

- Reverse path of the trip-select decoder. Samples the 16-line one-hot trip-level indication returned by the overvoltage comparator bank, where bit i means trip level i.
- Synchronizes and debounces the lines, then encodes them into a 4-bit level code.
- Delivers each new stable code to the digital controller over a valid/ready handshake.
- Flags illegal patterns: all-zero or multi-hot.

---
 rtl/overvoltage_trip_encoder.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/overvoltage_trip_encoder.sv
// overvoltage_trip_encoder
//
// Purpose: samples the 16-line one-hot trip-level indication from the overvoltage
// comparator bank, synchronizes and debounces it, encodes it to a 4-bit level code
// and delivers every new stable code to the controller over a valid/ready handshake.
// Zero and multi-hot patterns are reported with invalid set.
//
// Ports:
//   clk         block clock
//   rst         synchronous, active-high reset
//   en          enable; low forces IDLE and drops any pending report
//   onehot_in   asynchronous comparator one-hot level lines (bit i = trip level i)
//   code_out    encoded trip level (highest set bit)
//   code_valid  code_out/invalid hold a new report
//   code_ready  consumer accepts the report
//   invalid     reported pattern was zero or multi-hot; qualified by code_valid
//   overrun     sticky; a stable new pattern was displaced while a report was pending
//   peak_code   (OVERVOLTAGE_TRIP_ENCODER_PEAK_EN only) highest accepted valid code
//   peak_clr    (OVERVOLTAGE_TRIP_ENCODER_PEAK_EN only) clears peak_code
//
// Optional feature macro: OVERVOLTAGE_TRIP_ENCODER_PEAK_EN adds the peak tracker.

module overvoltage_trip_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] onehot_in,
  output logic [3:0]  code_out,
  output logic        code_valid,
  input  logic        code_ready,
  output logic        invalid,
`ifdef OVERVOLTAGE_TRIP_ENCODER_PEAK_EN
  output logic [3:0]  peak_code,
  input  logic        peak_clr,
`endif
  output logic        overrun
);

  localparam logic [7:0] CntMax = 8'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {StIdle, StSettle, StReport} state_e;

  state_e      state_q;
  logic [15:0] sync1_q, sync2_q;
  logic [15:0] cand_q;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] last_rep_q;
  logic        first_q;

  logic        match;
  logic        stable;
  logic        is_new;
  logic        accept;
  logic [3:0]  enc_code;
  logic        enc_invalid;

  // Synchronizer and debounce counter.
  assign match = (sync2_q == cand_q);

  always_comb begin
    cnt_d = cnt_q;
    if (!match) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Stability is judged on the edge where the counter reaches saturation, so the
  // report register is the only stage between the debounce and code_valid.
  assign stable = match && (cnt_d == CntMax);
  assign is_new = first_q || (cand_q != last_rep_q);
  assign accept = (state_q == StReport) && en && code_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= onehot_in;
      sync2_q <= sync1_q;
      if (!match) begin
        cand_q <= sync2_q;
      end
      cnt_q <= cnt_d;
    end
  end

  // Encoder: highest set bit wins; zero or more than one bit is invalid.
  always_comb begin
    logic seen;
    logic multi;
    enc_code = '0;
    seen     = 1'b0;
    multi    = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (cand_q[i]) begin
        enc_code = 4'(i);
        if (seen) begin
          multi = 1'b1;
        end
        seen = 1'b1;
      end
    end
    enc_invalid = !seen || multi;
  end

  // Report state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      code_out   <= '0;
      invalid    <= 1'b0;
      code_valid <= 1'b0;
      overrun    <= 1'b0;
      last_rep_q <= '0;
      first_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          code_valid <= 1'b0;
          if (en) begin
            state_q    <= StSettle;
            last_rep_q <= '0;
            first_q    <= 1'b1;
          end
        end
        StSettle: begin
          if (!en) begin
            state_q <= StIdle;
          end else if (stable && is_new) begin
            code_out   <= enc_code;
            invalid    <= enc_invalid;
            last_rep_q <= cand_q;
            first_q    <= 1'b0;
            code_valid <= 1'b1;
            state_q    <= StReport;
          end
        end
        StReport: begin
          if (!en) begin
            state_q    <= StIdle;
            code_valid <= 1'b0;
          end else if (accept) begin
            code_valid <= 1'b0;
            state_q    <= StSettle;
          end else if (stable && (cand_q != last_rep_q)) begin
            // Held report is kept; the new pattern goes out after the handshake.
            overrun <= 1'b1;
          end
        end
        default: begin
          state_q    <= StIdle;
          code_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef OVERVOLTAGE_TRIP_ENCODER_PEAK_EN
  // Peak tracker over accepted, valid reports; clear beats an update.
  always_ff @(posedge clk) begin
    if (rst) begin
      peak_code <= '0;
    end else if (peak_clr) begin
      peak_code <= '0;
    end else if (accept && !invalid && (code_out > peak_code)) begin
      peak_code <= code_out;
    end
  end
`endif

endmodule
